// File: rtl/fft16_pkg.sv
// Shared constants and types for the 16-point FFT frame sequencer.
package fft16_pkg;

   localparam int N_PTS       = 16;
   localparam int IDX_W       = 4;
   localparam int DEF_DATA_W  = 16;
   localparam int DEF_OUT_W   = 17;
   localparam int DEF_LATENCY = 64;

   // Input-side sequencer: FILL collects samples, SETTLE holds the core inputs
   // frozen while the core pipeline produces its result.
   typedef enum logic {
      FILL   = 1'b0,
      SETTLE = 1'b1
   } in_state_e;

endpackage

// File: rtl/fft16_out_bank.sv
// 16-entry result bank: parallel load from the core, serial drain with
// valid/ready/last.
//
// Handshake: a bin transfers on a rising edge where m_valid and m_ready are
// both high; m_re/m_im/m_last hold steady while m_valid=1 and m_ready=0.
module fft16_out_bank
   import fft16_pkg::*;
#(
   parameter int OUT_W = DEF_OUT_W
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   load,
   input  logic [N_PTS*OUT_W-1:0] load_re,
   input  logic [N_PTS*OUT_W-1:0] load_im,
   input  logic                   m_ready,
   output logic                   m_valid,
   output logic [OUT_W-1:0]       m_re,
   output logic [OUT_W-1:0]       m_im,
   output logic                   m_last,
   output logic                   full,
   output logic                   drain_last
);

   logic [OUT_W-1:0] bank_re_q [N_PTS];
   logic [OUT_W-1:0] bank_re_d [N_PTS];
   logic [OUT_W-1:0] bank_im_q [N_PTS];
   logic [OUT_W-1:0] bank_im_d [N_PTS];
   logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
   logic             full_q, full_d;
   logic             m_hs;
   logic             last_slot;

   assign m_hs       = full_q & m_ready;
   assign last_slot  = (rd_idx_q == IDX_W'(N_PTS - 1));
   assign drain_last = m_hs & last_slot;

   assign m_valid = full_q;
   assign m_re    = bank_re_q[rd_idx_q];
   assign m_im    = bank_im_q[rd_idx_q];
   assign m_last  = full_q & last_slot;
   assign full    = full_q;

   // Next bank contents and read pointer. The parent only asserts load when
   // the bank is empty or its final bin is leaving on this edge, so a load
   // never overwrites unread data; load wins over the drain update.
   always_comb begin
      rd_idx_d = rd_idx_q;
      full_d   = full_q;
      for (int k = 0; k < N_PTS; k++) begin
         bank_re_d[k] = bank_re_q[k];
         bank_im_d[k] = bank_im_q[k];
      end
      if (load) begin
         for (int k = 0; k < N_PTS; k++) begin
            bank_re_d[k] = load_re[OUT_W*k +: OUT_W];
            bank_im_d[k] = load_im[OUT_W*k +: OUT_W];
         end
         full_d   = 1'b1;
         rd_idx_d = '0;
      end else if (m_hs) begin
         if (last_slot) begin
            full_d   = 1'b0;
            rd_idx_d = '0;
         end else begin
            rd_idx_d = rd_idx_q + IDX_W'(1);
         end
      end
   end

   // Bank, pointer and full flag registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         rd_idx_q <= '0;
         full_q   <= 1'b0;
         for (int k = 0; k < N_PTS; k++) begin
            bank_re_q[k] <= '0;
            bank_im_q[k] <= '0;
         end
      end else begin
         rd_idx_q <= rd_idx_d;
         full_q   <= full_d;
         for (int k = 0; k < N_PTS; k++) begin
            bank_re_q[k] <= bank_re_d[k];
            bank_im_q[k] <= bank_im_d[k];
         end
      end
   end

endmodule

// File: rtl/fft16_frame_ctrl.sv
// Frame sequencer around the 16-point CORDIC FFT core: assembles serial
// samples into a frame, holds the core inputs for the pipeline latency,
// captures the results and streams them out serially.
//
// Handshakes: s_* and m_* are valid/ready; a transfer happens on a rising
// edge where valid and ready are both high. Valid never depends on ready.
module fft16_frame_ctrl
   import fft16_pkg::*;
#(
   parameter int DATA_W  = DEF_DATA_W,
   parameter int OUT_W   = DEF_OUT_W,
   parameter int LATENCY = DEF_LATENCY   // must be >= 1
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    s_valid,
   output logic                    s_ready,
   input  logic [DATA_W-1:0]       s_re,
   input  logic [DATA_W-1:0]       s_im,
   output logic [N_PTS*DATA_W-1:0] fft_xin,
   output logic [N_PTS*DATA_W-1:0] fft_yin,
   input  logic [N_PTS*OUT_W-1:0]  fft_xout,
   input  logic [N_PTS*OUT_W-1:0]  fft_yout,
   output logic                    m_valid,
   input  logic                    m_ready,
   output logic [OUT_W-1:0]        m_re,
   output logic [OUT_W-1:0]        m_im,
   output logic                    m_last,
   output logic                    busy
);

   localparam int              CNT_W    = $clog2(LATENCY + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(LATENCY);

   in_state_e         in_state_q, in_state_d;
   logic [IDX_W-1:0]  wr_idx_q, wr_idx_d;
   logic [CNT_W-1:0]  settle_cnt_q, settle_cnt_d;
   logic [DATA_W-1:0] in_re_q [N_PTS];
   logic [DATA_W-1:0] in_re_d [N_PTS];
   logic [DATA_W-1:0] in_im_q [N_PTS];
   logic [DATA_W-1:0] in_im_d [N_PTS];

   logic s_hs;
   logic settle_done;
   logic capture;
   logic out_full;
   logic drain_last;

   assign s_ready     = (in_state_q == FILL);
   assign s_hs        = s_valid & s_ready;
   // ">=" also covers the saturated count while waiting on a full output bank.
   assign settle_done = (in_state_q == SETTLE) && (settle_cnt_q >= CNT_LAST);
   // Capture when the bank is free, or on the very edge its last bin leaves,
   // so the output stream can continue without a bubble.
   assign capture     = settle_done && (!out_full || drain_last);
   assign busy        = (in_state_q != FILL) || (wr_idx_q != '0) || out_full;

   // Input FSM next state, write pointer, settle counter and input bank.
   always_comb begin
      in_state_d   = in_state_q;
      wr_idx_d     = wr_idx_q;
      settle_cnt_d = settle_cnt_q;
      for (int k = 0; k < N_PTS; k++) begin
         in_re_d[k] = in_re_q[k];
         in_im_d[k] = in_im_q[k];
      end
      unique case (in_state_q)
         FILL: begin
            if (s_hs) begin
               in_re_d[wr_idx_q] = s_re;
               in_im_d[wr_idx_q] = s_im;
               if (wr_idx_q == IDX_W'(N_PTS - 1)) begin
                  wr_idx_d     = '0;
                  settle_cnt_d = '0;
                  in_state_d   = SETTLE;
               end else begin
                  wr_idx_d = wr_idx_q + IDX_W'(1);
               end
            end
         end
         SETTLE: begin
            if (settle_cnt_q != CNT_MAX) begin
               settle_cnt_d = settle_cnt_q + CNT_W'(1);
            end
            if (capture) begin
               in_state_d = FILL;
            end
         end
         default: in_state_d = FILL;
      endcase
   end

   // Input FSM and input bank registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         in_state_q   <= FILL;
         wr_idx_q     <= '0;
         settle_cnt_q <= '0;
         for (int k = 0; k < N_PTS; k++) begin
            in_re_q[k] <= '0;
            in_im_q[k] <= '0;
         end
      end else begin
         in_state_q   <= in_state_d;
         wr_idx_q     <= wr_idx_d;
         settle_cnt_q <= settle_cnt_d;
         for (int k = 0; k < N_PTS; k++) begin
            in_re_q[k] <= in_re_d[k];
            in_im_q[k] <= in_im_d[k];
         end
      end
   end

   // Present the input bank to the core; it only changes during FILL.
   always_comb begin
      fft_xin = '0;
      fft_yin = '0;
      for (int k = 0; k < N_PTS; k++) begin
         fft_xin[DATA_W*k +: DATA_W] = in_re_q[k];
         fft_yin[DATA_W*k +: DATA_W] = in_im_q[k];
      end
   end

   fft16_out_bank #(
      .OUT_W (OUT_W)
   ) u_out_bank (
      .clock      (clock),
      .reset      (reset),
      .load       (capture),
      .load_re    (fft_xout),
      .load_im    (fft_yout),
      .m_ready    (m_ready),
      .m_valid    (m_valid),
      .m_re       (m_re),
      .m_im       (m_im),
      .m_last     (m_last),
      .full       (out_full),
      .drain_last (drain_last)
   );

endmodule

// File: tb/tb_fft16_frame_ctrl.sv
// Directed bench for fft16_frame_ctrl with a delay-line stand-in for the core.
module tb_fft16_frame_ctrl;
   import fft16_pkg::*;

   localparam int DW  = 16;
   localparam int OW  = 17;
   localparam int LAT = 64;
   localparam int CW  = 256;

   logic                 clock;
   logic                 reset;
   logic                 s_valid;
   logic                 s_ready;
   logic [DW-1:0]        s_re;
   logic [DW-1:0]        s_im;
   logic [N_PTS*DW-1:0]  fft_xin;
   logic [N_PTS*DW-1:0]  fft_yin;
   logic [N_PTS*OW-1:0]  fft_xout;
   logic [N_PTS*OW-1:0]  fft_yout;
   logic                 m_valid;
   logic                 m_ready;
   logic [OW-1:0]        m_re;
   logic [OW-1:0]        m_im;
   logic                 m_last;
   logic                 busy;

   int n_checks   = 0;
   int n_errors   = 0;
   int n_spurious = 0;

   // Expected bins: {last, re, im}
   logic [2*OW:0] exp_q[$];

   fft16_frame_ctrl #(
      .DATA_W  (DW),
      .OUT_W   (OW),
      .LATENCY (LAT)
   ) dut (
      .clock    (clock),
      .reset    (reset),
      .s_valid  (s_valid),
      .s_ready  (s_ready),
      .s_re     (s_re),
      .s_im     (s_im),
      .fft_xin  (fft_xin),
      .fft_yin  (fft_yin),
      .fft_xout (fft_xout),
      .fft_yout (fft_yout),
      .m_valid  (m_valid),
      .m_ready  (m_ready),
      .m_re     (m_re),
      .m_im     (m_im),
      .m_last   (m_last),
      .busy     (busy)
   );

   // Clock
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Watchdog
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
      $fatal(1, "watchdog");
   end

   // Core stand-in: the capture edge is the LATENCY-th edge after the inputs
   // settle, so the result must be present just before it: LATENCY-1 stages.
   logic [N_PTS*DW-1:0] dx [LAT-1];
   logic [N_PTS*DW-1:0] dy [LAT-1];

   always_ff @(posedge clock) begin
      dx[0] <= fft_xin;
      dy[0] <= fft_yin;
      for (int i = 1; i < LAT - 1; i++) begin
         dx[i] <= dx[i-1];
         dy[i] <= dy[i-1];
      end
   end

   always_comb begin
      fft_xout = '0;
      fft_yout = '0;
      for (int k = 0; k < N_PTS; k++) begin
         fft_xout[OW*k +: OW] = {{(OW-DW){dx[LAT-2][DW*k+DW-1]}}, dx[LAT-2][DW*k +: DW]};
         fft_yout[OW*k +: OW] = {{(OW-DW){dy[LAT-2][DW*k+DW-1]}}, dy[LAT-2][DW*k +: DW]};
      end
   end

   task automatic check_val(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [OW-1:0] sext(input int v);
      logic [DW-1:0] t;
      t = DW'(v);
      return {{(OW-DW){t[DW-1]}}, t};
   endfunction

   function automatic logic [N_PTS*DW-1:0] packed_vec(input int base, input int step);
      logic [N_PTS*DW-1:0] r;
      r = '0;
      for (int k = 0; k < N_PTS; k++) r[DW*k +: DW] = DW'(base + k * step);
      return r;
   endfunction

   // Scoreboard: checks every accepted bin and output stability during stalls.
   logic [OW-1:0] hold_re, hold_im;
   logic          hold_last;
   bit            stalled = 0;
   always @(negedge clock) begin
      logic [2*OW:0] e;
      if (!reset && m_valid) begin
         if (stalled) begin
            check_val("hold_re", m_re, hold_re);
            check_val("hold_im", m_im, hold_im);
            check_val("hold_last", m_last, hold_last);
         end
         if (m_ready) begin
            stalled = 0;
            if (exp_q.size() == 0) begin
               n_spurious++;
               $display("FAIL spurious_bin: got re=%0h im=%0h with nothing expected", m_re, m_im);
            end else begin
               e = exp_q.pop_front();
               check_val("bin_re", m_re, e[2*OW-1:OW]);
               check_val("bin_im", m_im, e[OW-1:0]);
               check_val("bin_last", m_last, e[2*OW]);
            end
         end else begin
            stalled   = 1;
            hold_re   = m_re;
            hold_im   = m_im;
            hold_last = m_last;
         end
      end else begin
         stalled = 0;
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Offer one sample and wait (bounded) for it to be accepted.
   task automatic send_sample(input int re, input int im);
      int g;
      s_valid = 1'b1;
      s_re    = DW'(re);
      s_im    = DW'(im);
      g = 0;
      @(negedge clock);
      while (!s_ready && g < 500) begin
         @(negedge clock);
         g++;
      end
      if (g >= 500) check_val("s_ready_timeout", s_ready, 1);
      @(posedge clock);
      #1;
      s_valid = 1'b0;
   endtask

   // Send a 16-sample frame re=re0+k*dre, im=im0+k*dim and queue its bins.
   task automatic send_frame(input int re0, input int dre, input int im0, input int dim, input bit junk);
      for (int k = 0; k < N_PTS; k++) send_sample(re0 + k * dre, im0 + k * dim);
      for (int k = 0; k < N_PTS; k++)
         exp_q.push_back({(k == N_PTS - 1), sext(re0 + k * dre), sext(im0 + k * dim)});
      if (junk) begin
         s_valid = 1'b1;
         s_re    = 16'h7FFF;
         s_im    = 16'h7FFF;
      end
   endtask

   task automatic wait_m_valid(output int cyc);
      cyc = 0;
      while (!m_valid && cyc < 300) begin
         tick();
         cyc++;
      end
   endtask

   task automatic wait_drain(input string tag);
      int g;
      g = 0;
      while ((exp_q.size() != 0 || m_valid) && g < 2000) begin
         tick();
         g++;
      end
      check_val(tag, exp_q.size(), 0);
   endtask

   initial begin
      int  cyc;
      int  n;
      int  drops;
      bit  sr_seen;

      reset   = 1'b1;
      s_valid = 1'b0;
      s_re    = '0;
      s_im    = '0;
      m_ready = 1'b1;
      repeat (3) tick();

      // Reset state
      check_val("rst_s_ready", s_ready, 1);
      check_val("rst_m_valid", m_valid, 0);
      check_val("rst_m_last", m_last, 0);
      check_val("rst_busy", busy, 0);
      check_val("rst_m_re", m_re, 0);
      check_val("rst_m_im", m_im, 0);
      check_val("rst_fft_xin", fft_xin, 0);
      check_val("rst_fft_yin", fft_yin, 0);
      reset = 1'b0;
      tick();

      // 1: single frame, latency and ordering
      send_frame(0, 100, 0, -1, 0);
      check_val("t1_s_ready_settle", s_ready, 0);
      check_val("t1_m_valid_settle", m_valid, 0);
      check_val("t1_busy", busy, 1);
      check_val("t1_fft_xin", fft_xin, packed_vec(0, 100));
      check_val("t1_fft_yin", fft_yin, packed_vec(0, -1));
      cyc = 0;
      sr_seen = 0;
      while (!m_valid && cyc < 300) begin
         if (s_ready) sr_seen = 1;
         tick();
         cyc++;
      end
      check_val("t1_latency", cyc, LAT);
      check_val("t1_s_ready_held_low", sr_seen, 0);
      check_val("t1_s_ready_after", s_ready, 1);
      n = 0;
      while (m_valid && n < 40) begin
         tick();
         n++;
      end
      check_val("t1_burst_len", n, N_PTS);
      wait_drain("t1_drain");
      check_val("t1_idle_busy", busy, 0);

      // 2: back-to-back frames
      send_frame(1000, 1, -500, 2, 0);
      send_frame(-7, 250, 12, -33, 0);
      wait_m_valid(cyc);
      check_val("t2_b_latency", cyc, LAT);
      wait_drain("t2_drain");

      // 3: output stalled, second frame waits in SETTLE
      send_frame(-2000, 37, 300, -11, 0);
      wait_m_valid(cyc);
      m_ready = 1'b0;
      send_frame(5, -3, 7000, 13, 0);
      repeat (80) tick();
      check_val("t3_s_ready_stall", s_ready, 0);
      check_val("t3_m_valid_stall", m_valid, 1);
      check_val("t3_busy", busy, 1);
      check_val("t3_fft_xin_frozen", fft_xin, packed_vec(5, -3));
      check_val("t3_fft_yin_frozen", fft_yin, packed_vec(7000, 13));
      check_val("t3_a_bin0_held", m_re, sext(-2000));
      m_ready = 1'b1;
      drops = 0;
      for (int i = 0; i < 2 * N_PTS; i++) begin
         if (!m_valid) drops++;
         tick();
      end
      check_val("t3_m_valid_gaps", drops, 0);
      check_val("t3_m_valid_end", m_valid, 0);
      wait_drain("t3_drain");

      // 4: m_ready toggling during drain
      send_frame(123, 11, -77, 5, 0);
      wait_m_valid(cyc);
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         m_ready = (n % 2 == 0);
         tick();
         n++;
      end
      m_ready = 1'b1;
      check_val("t4_toggle_cycles", n, 2 * N_PTS - 1);
      wait_drain("t4_drain");

      // 5: reset discards a partial frame
      for (int k = 0; k < 7; k++) send_sample(9 + k, 9 - k);
      check_val("t5_busy_partial", busy, 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_val("t5_busy_after_rst", busy, 0);
      check_val("t5_s_ready_after_rst", s_ready, 1);
      check_val("t5_m_valid_after_rst", m_valid, 0);
      check_val("t5_fft_xin_after_rst", fft_xin, 0);
      send_frame(-1, -1000, 32767, -2000, 0);
      check_val("t5_fft_xin_fresh", fft_xin, packed_vec(-1, -1000));
      wait_drain("t5_drain");

      // 6: s_valid held with junk through SETTLE
      send_frame(400, -50, -9, 9, 1);
      n = 0;
      while (!s_ready && n < 300) begin
         tick();
         n++;
      end
      s_valid = 1'b0;
      check_val("t6_settle_len", n, LAT);
      check_val("t6_fft_xin_unchanged", fft_xin, packed_vec(400, -50));
      check_val("t6_fft_yin_unchanged", fft_yin, packed_vec(-9, 9));
      send_frame(2, 2, -2, -2, 0);
      wait_drain("t6_drain");
      check_val("t6_idle_busy", busy, 0);

      check_val("spurious_bins", n_spurious, 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + n_spurious);
      $finish;
   end

endmodule
